// File: rtl/wb_fifo_write_arbiter.sv
// Round-robin arbiter sharing one wishbone FIFO push port among NUM_REQ pipelined
// wishbone controllers; a grant lasts one bus cycle, capped at MAX_BURST accepted beats.
module wb_fifo_write_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int DATA_WIDTH      = 8,
  parameter int MAX_BURST       = 8,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ-1:0]            req_cyc_i,
  input  logic [NUM_REQ-1:0]            req_stb_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dat_i,
  output logic [NUM_REQ-1:0]            req_stall_o,
  output logic [NUM_REQ-1:0]            req_ack_o,
  output logic                          dev_cyc_o,
  output logic                          dev_stb_o,
  output logic [DATA_WIDTH-1:0]         dev_dat_o,
  input  logic                          dev_stall_i,
  input  logic                          dev_ack_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          err_o
);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RELEASE} state_t;

  state_t                r_state, w_state_nxt;
  logic [NUM_REQ-1:0]    r_grant, w_grant_nxt;
  logic [IW-1:0]         r_last, w_last_nxt;
  logic [OW-1:0]         r_out, w_out_nxt;
  logic [BW-1:0]         r_beats, w_beats_nxt;
  logic                  r_err, w_err_nxt;

  logic [DATA_WIDTH-1:0] w_dat [NUM_REQ];
  logic [IW-1:0]         w_pick;
  logic                  w_hold;
  logic                  w_stb;
  logic                  w_accept;
  logic                  w_ack_ok;

  // First requester with cyc high, searching from last+1 with wrap-around.
  function automatic logic [IW-1:0] f_pick(input logic [NUM_REQ-1:0] cyc,
                                           input logic [IW-1:0]      last);
    logic [IW-1:0] win;
    logic          found;
    int            idx;
    win   = last;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(last) + i) % NUM_REQ;
      if (!found && cyc[IW'(idx)]) begin
        found = 1'b1;
        win   = IW'(idx);
      end
    end
    return win;
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      w_dat[k] = req_dat_i[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign w_pick = f_pick(req_cyc_i, r_last);

  always_comb begin
    w_hold      = (r_out == OW'(MAX_OUTSTANDING));
    w_stb       = 1'b0;
    dev_cyc_o   = 1'b0;
    dev_stb_o   = 1'b0;
    dev_dat_o   = '0;
    req_stall_o = '1;
    req_ack_o   = '0;
    w_ack_ok    = dev_ack_i && (r_state != IDLE) && (r_out != '0);
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_last_nxt  = r_last;
    w_beats_nxt = r_beats;
    // An ack with nothing outstanding (or while idle) is dropped and flagged.
    w_err_nxt   = r_err || (dev_ack_i && !w_ack_ok);

    case (r_state)
      BUSY: begin
        w_stb                = req_stb_i[r_last] && !w_hold;
        dev_cyc_o            = req_cyc_i[r_last];
        dev_stb_o            = w_stb;
        dev_dat_o            = w_dat[r_last];
        req_stall_o[r_last]  = dev_stall_i || w_hold;
        req_ack_o[r_last]    = w_ack_ok;
      end
      RELEASE: begin
        dev_cyc_o            = 1'b1;
        req_ack_o[r_last]    = w_ack_ok;
      end
      default: ;
    endcase

    w_accept  = w_stb && !dev_stall_i;
    w_out_nxt = r_out + OW'(w_accept) - OW'(w_ack_ok);

    case (r_state)
      IDLE: begin
        if (|req_cyc_i) begin
          w_state_nxt         = BUSY;
          w_last_nxt          = w_pick;
          w_grant_nxt         = '0;
          w_grant_nxt[w_pick] = 1'b1;
        end
      end
      BUSY: begin
        if (w_accept) w_beats_nxt = r_beats + BW'(1);
        if (!req_cyc_i[r_last])
          w_state_nxt = (w_out_nxt == '0) ? IDLE : RELEASE;
        else if (w_accept && (w_beats_nxt == BW'(MAX_BURST)))
          w_state_nxt = RELEASE;
      end
      RELEASE: begin
        if (w_out_nxt == '0) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase

    if (w_state_nxt == IDLE) begin
      w_grant_nxt = '0;
      w_beats_nxt = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_last  <= IW'(NUM_REQ - 1);
      r_out   <= '0;
      r_beats <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_last  <= w_last_nxt;
      r_out   <= w_out_nxt;
      r_beats <= w_beats_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign grant_o = r_grant;
  assign err_o   = r_err;

endmodule

// File: doc/wb_fifo_write_arbiter.md
Name: wb_fifo_write_arbiter

Overview:
- Round-robin arbiter that shares the write (push) port of one wishbone FIFO device among NUM_REQ upstream wishbone controllers.
- Pipelined wishbone with stall and ack.
- Grant is held for a whole bus cycle (cyc), capped at MAX_BURST accepted beats so that no requester can starve the others.
- Tracks outstanding acks and routes each downstream ack back to the owning requester.

Parameters:
- NUM_REQ, 4: number of upstream controllers (2..8).
- DATA_WIDTH, 8: data width, matching the FIFO byte buffer.
- MAX_BURST, 8: maximum beats accepted per grant before a forced release.
- MAX_OUTSTANDING, 4: maximum accepted-but-unacked beats.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  reset; asynchronous, active-low.
- req_cyc_i  in  NUM_REQ  per-requester cyc.
- req_stb_i  in  NUM_REQ  per-requester stb.
- req_dat_i  in  NUM_REQ*DATA_WIDTH  per-requester data; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- req_stall_o  out  NUM_REQ  per-requester stall.
- req_ack_o  out  NUM_REQ  per-requester ack.
- dev_cyc_o  out  1  cyc to the FIFO.
- dev_stb_o  out  1  stb to the FIFO.
- dev_dat_o  out  DATA_WIDTH  data to the FIFO.
- dev_stall_i  in  1  FIFO stall (FIFO full).
- dev_ack_i  in  1  FIFO ack.
- grant_o  out  NUM_REQ  one-hot registered grant; all zero when IDLE.
- err_o  out  1  sticky protocol error.

Behaviour:
- Reset (rst_ni=0, asynchronous):
  - state=IDLE, grant_o=0, outstanding=0, beat count=0, err_o=0.
  - last_grant=NUM_REQ-1, so requester 0 wins the first arbitration.
  - All outputs 0 except req_stall_o, which is all ones.
  - Reset asserted mid-transfer aborts the transfer and drops all pending acks.
- States: IDLE, BUSY, RELEASE.
- IDLE:
  - dev_cyc_o=0, dev_stb_o=0, req_stall_o all ones.
  - If any req_cyc_i is high, the winner is the first requester with cyc high, searching from last_grant+1 with wrap-around.
  - grant_o and last_grant are registered; BUSY is entered on the next edge (1-cycle arbitration latency).
- BUSY (granted index g):
  - dev_cyc_o=req_cyc_i[g], dev_dat_o=req_dat_i[g].
  - dev_stb_o=req_stb_i[g] && !hold, where hold = (outstanding==MAX_OUTSTANDING).
  - req_stall_o[g]=dev_stall_i || hold; every other req_stall_o bit is 1.
  - accept = dev_stb_o && !dev_stall_i. On accept: outstanding++, beats++.
  - dev_ack_i increments nothing; it decrements outstanding and is passed combinationally to req_ack_o[g] only.
  - Accept and ack in the same cycle leave outstanding unchanged.
  - req_cyc_i[g] falls with outstanding==0 → IDLE; with outstanding>0 → RELEASE.
  - Accept bringing beats to MAX_BURST → RELEASE on the next edge.
- RELEASE:
  - dev_cyc_o=1, dev_stb_o=0, req_stall_o all ones.
  - Acks are still routed to g.
  - When outstanding==0 (including a final ack this cycle), go to IDLE on the next edge; clear grant_o and beats.
- Width rules:
  - outstanding is $clog2(MAX_OUTSTANDING+1) bits and never exceeds MAX_OUTSTANDING.
  - beats is $clog2(MAX_BURST+1) bits and is cleared on entry to IDLE.
- err_o:
  - Set on dev_ack_i with outstanding==0, or dev_ack_i while IDLE. The ack is dropped and outstanding stays 0.
  - Cleared only by reset.
- Fairness:
  - After a grant ends, the granted requester has lowest priority at the next arbitration.
  - A requester holding cyc continuously gets at most MAX_BURST beats per NUM_REQ grants when others are requesting.

Test Plan:
- Single requester: reset, then req 2 cyc/stb for 3 beats with dat 0x11,0x22,0x33; the FIFO acks each one cycle after accept.
  → grant_o=0100 one cycle after cyc; dev_dat_o carries 0x11,0x22,0x33; req_ack_o[2] pulses 3 times; returns to IDLE once cyc drops and outstanding=0.
- Contention: reqs 0, 1 and 3 raise cyc simultaneously, each for 2 beats.
  → grant order 0,1,3; each gets exactly 2 acks; non-granted stall stays 1 throughout.
- Forced release: req 1 holds cyc/stb for 20 beats, req 0 also requesting, MAX_BURST=8.
  → req 1 gets 8 beats, RELEASE until acks drain, then req 0 is granted; req 1 is regranted afterwards.
- Backpressure: FIFO full (dev_stall_i=1) for 5 cycles mid-burst, then acks withheld until outstanding=4.
  → no accepts while stalled; req_stall_o[g]=1 at outstanding=4; dev_stb_o=0 in that state.
- Boundaries:
  - Same-cycle accept+ack → outstanding unchanged.
  - Stray dev_ack_i in IDLE → err_o=1 sticky, no req_ack_o pulse.
  - rst_ni pulsed low mid-BUSY → all outputs return to reset values immediately; the next grant goes to requester 0.
